// File: rtl/kgp_multicycle_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer: turns decoded control into one-cycle datapath strobes.
// Latency: 4+L cycles per ALU/store, 5+2L per load (L = MEM_LAT); no backpressure, run is sampled only at instruction boundaries.
// Optional perf counters (cycleCnt/instrCnt) are built only when KGP_SEQ_PERF_CNT_EN is defined.
module kgp_multicycle_seq #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        halt,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        brLink,
    input  logic [2:0]  branch,
    input  logic        brTaken,
    output logic        imemEn,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        pcSrcBr,
    output logic        dmemEn,
    output logic        dmemWe,
    output logic        rfWrite,
    output logic        done,
    output logic        busy,
    output logic [2:0]  state,
    output logic [31:0] cycleCnt,
    output logic [31:0] instrCnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_MWAIT  = 3'd6,
        S_WB     = 3'd7
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    state_t     cur;
    state_t     nxt;
    logic [1:0] wcnt;
    logic [1:0] nxt_wcnt;
    logic       instr_end;
    logic       halt_take;
    logic       br_class;

    assign br_class = |branch;
    assign busy     = (cur != S_IDLE);
    assign state    = cur;
    // Branch target select follows brTaken live while the PC strobe is up.
    assign pcSrcBr  = pcWrite & br_class & brTaken;

    always_comb begin
        nxt       = cur;
        nxt_wcnt  = 2'd0;
        instr_end = 1'b0;
        halt_take = 1'b0;
        case (cur)
            S_IDLE: begin
                if (run) nxt = S_FETCH;
            end
            S_FETCH: begin
                nxt = S_FWAIT;
            end
            S_FWAIT: begin
                if (wcnt == WAIT_LAST) nxt = S_DECODE;
                else                   nxt_wcnt = wcnt + 2'd1;
            end
            S_DECODE: begin
                if (halt) begin
                    nxt       = S_IDLE;
                    halt_take = 1'b1;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (memWrite || memRead)              nxt = S_MEM;
                else if (regWrite || (br_class && brLink)) nxt = S_WB;
                else                                  instr_end = 1'b1;
            end
            S_MEM: begin
                // A simultaneous read+write is a store: no read-data wait, no write-back.
                if (memWrite) instr_end = 1'b1;
                else          nxt = S_MWAIT;
            end
            S_MWAIT: begin
                if (wcnt == WAIT_LAST) nxt = S_WB;
                else                   nxt_wcnt = wcnt + 2'd1;
            end
            S_WB: begin
                instr_end = 1'b1;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
        if (instr_end) nxt = run ? S_FETCH : S_IDLE;
    end

    // Strobes are registered from the next state so each one is aligned with its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            wcnt    <= 2'd0;
            imemEn  <= 1'b0;
            irWrite <= 1'b0;
            pcWrite <= 1'b0;
            dmemEn  <= 1'b0;
            dmemWe  <= 1'b0;
            rfWrite <= 1'b0;
            done    <= 1'b0;
        end else begin
            cur     <= nxt;
            wcnt    <= nxt_wcnt;
            imemEn  <= (nxt == S_FETCH);
            irWrite <= (nxt == S_FWAIT) && (nxt_wcnt == WAIT_LAST);
            pcWrite <= (nxt == S_EXEC);
            dmemEn  <= (nxt == S_MEM);
            dmemWe  <= (nxt == S_MEM) && memWrite;
            rfWrite <= (nxt == S_WB);
            done    <= halt_take;
        end
    end

`ifdef KGP_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            if (busy)                   cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_end || halt_take) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycleCnt = cycle_cnt_q;
    assign instrCnt = instr_cnt_q;
`else
    assign cycleCnt = 32'd0;
    assign instrCnt = 32'd0;
`endif

endmodule

// File: tb/tb_kgp_multicycle_seq.sv
// Bench for kgp_multicycle_seq: per-instruction expected traces built from instruction class, random program mix.
module tb_kgp_multicycle_seq;

    localparam int L = 2;
`ifdef KGP_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_STORE_RW, K_BR, K_BRL, K_NOP, K_HALT} kind_t;

    logic        clk = 1'b0;
    logic        rst_n, run, halt, regWrite, memRead, memWrite, brLink, brTaken;
    logic [2:0]  branch;
    logic        imemEn, irWrite, pcWrite, pcSrcBr, dmemEn, dmemWe, rfWrite, done, busy;
    logic [2:0]  state;
    logic [31:0] cycleCnt, instrCnt;

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;
    int exp_instr = 0;
    logic [11:0] trace[$];

    kgp_multicycle_seq #(.MEM_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt(halt), .regWrite(regWrite),
        .memRead(memRead), .memWrite(memWrite), .brLink(brLink), .branch(branch),
        .brTaken(brTaken), .imemEn(imemEn), .irWrite(irWrite), .pcWrite(pcWrite),
        .pcSrcBr(pcSrcBr), .dmemEn(dmemEn), .dmemWe(dmemWe), .rfWrite(rfWrite),
        .done(done), .busy(busy), .state(state), .cycleCnt(cycleCnt), .instrCnt(instrCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {state, imemEn, irWrite, pcWrite, pcSrcBr, dmemEn, dmemWe, rfWrite, done, busy}
    function automatic logic [11:0] ev(input int st, input logic [7:0] f);
        return {3'(st), f, st != 0};
    endfunction

    function automatic logic [11:0] obsv();
        return {state, imemEn, irWrite, pcWrite, pcSrcBr, dmemEn, dmemWe, rfWrite, done, busy};
    endfunction

    function automatic int cpi(input kind_t k);
        case (k)
            K_ALU, K_STORE, K_STORE_RW, K_BRL: return 4 + L;
            K_LOAD:                           return 5 + 2 * L;
            K_BR, K_NOP:                      return 3 + L;
            default:                          return 2 + L;
        endcase
    endfunction

    // Expected per-cycle outputs for one instruction of class k.
    function automatic void build(input kind_t k, input bit tk);
        bit is_br;
        is_br = (k == K_BR) || (k == K_BRL);
        trace.delete();
        trace.push_back(ev(1, 8'b1000_0000));
        for (int i = 0; i < L; i++) trace.push_back(ev(2, {1'b0, i == L - 1, 6'b0}));
        trace.push_back(ev(3, 8'b0));
        if (k == K_HALT) begin
            trace.push_back(ev(0, 8'b0000_0001));
            return;
        end
        trace.push_back(ev(4, {2'b00, 1'b1, is_br && tk, 4'b0}));
        if (k == K_LOAD || k == K_STORE || k == K_STORE_RW)
            trace.push_back(ev(5, {4'b0, 1'b1, k != K_LOAD, 2'b0}));
        if (k == K_LOAD)
            for (int i = 0; i < L; i++) trace.push_back(ev(6, 8'b0));
        if (k == K_ALU || k == K_LOAD || k == K_BRL)
            trace.push_back(ev(7, 8'b0000_0010));
    endfunction

    task automatic set_kind(input kind_t k, input bit tk);
        halt = 1'b0; regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        brLink = 1'b0; branch = 3'd0; brTaken = tk;
        case (k)
            K_ALU:      regWrite = 1'b1;
            K_LOAD:     begin memRead = 1'b1; regWrite = 1'b1; end
            K_STORE:    memWrite = 1'b1;
            K_STORE_RW: begin memWrite = 1'b1; memRead = 1'b1; end
            K_BR:       branch = 3'($urandom_range(1, 7));
            K_BRL:      begin branch = 3'($urandom_range(1, 7)); brLink = 1'b1; end
            K_NOP:      brLink = 1'($urandom_range(0, 1));
            default:    begin halt = 1'b1; regWrite = 1'($urandom_range(0, 1)); end
        endcase
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, ".cycleCnt"}, cycleCnt, PERF ? exp_cyc : 0);
        chk({tag, ".instrCnt"}, instrCnt, PERF ? exp_instr : 0);
    endtask

    // Entered at the negedge where the DUT sits in FETCH; leaves at the negedge after the instruction.
    task automatic do_instr(input kind_t k, input bit tk, input bit run_end, input bit toggle);
        int busy_n;
        int last_busy;
        string tag;
        busy_n = 0;
        build(k, tk);
        last_busy = (k == K_HALT) ? trace.size() - 2 : trace.size() - 1;
        tag = $sformatf("%s", k.name());
        foreach (trace[i]) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("%s.c%0d", tag, i), {20'd0, obsv()}, {20'd0, trace[i]});
            chk_cnt($sformatf("%s.c%0d", tag, i));
            if (busy) busy_n++;
            if (trace[i][11:9] != 3'd0) exp_cyc++;
            if (i == last_busy) exp_instr++;
            if (i == 0) set_kind(k, tk);
            if (toggle && i == 1) run = 1'b0;
            if (toggle && i == 2) run = 1'b1;
            if (i == trace.size() - 1) run = run_end;
        end
        chk({tag, ".cpi"}, busy_n, cpi(k));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0;
        set_kind(K_NOP, 1'b0);
        brLink = 1'b0;
        @(negedge clk);
        chk("reset.outputs", {20'd0, obsv()}, 32'd0);
        chk_cnt("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.run0", {20'd0, obsv()}, 32'd0);
        run = 1'b1;
        @(negedge clk);

        // Directed: one of each class, both branch-condition polarities, halt, run glitch.
        do_instr(K_ALU,      1'b0, 1'b1, 1'b0);
        do_instr(K_LOAD,     1'b0, 1'b1, 1'b0);
        do_instr(K_STORE_RW, 1'b1, 1'b1, 1'b0);
        do_instr(K_STORE,    1'b0, 1'b1, 1'b0);
        do_instr(K_BRL,      1'b1, 1'b1, 1'b0);
        do_instr(K_BRL,      1'b0, 1'b1, 1'b0);
        do_instr(K_BR,       1'b1, 1'b1, 1'b0);
        do_instr(K_BR,       1'b0, 1'b1, 1'b0);
        do_instr(K_NOP,      1'b1, 1'b1, 1'b0);
        do_instr(K_HALT,     1'b0, 1'b1, 1'b0);
        do_instr(K_ALU,      1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 30; n++)
            do_instr(kind_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1,
                     1'($urandom_range(0, 1)));

        // Reset in the middle of a load's read wait.
        set_kind(K_LOAD, 1'b0);
        for (int i = 0; i < L + 4; i++) @(negedge clk);
        chk("pre_reset.state", {29'd0, state}, 32'd6);
        rst_n = 1'b0;
        #1;
        chk("midreset.outputs", {20'd0, obsv()}, 32'd0);
        chk("midreset.cycleCnt", cycleCnt, 32'd0);
        chk("midreset.instrCnt", instrCnt, 32'd0);
        exp_cyc = 0;
        exp_instr = 0;
        @(negedge clk);
        chk("held_reset.outputs", {20'd0, obsv()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 12; n++)
            do_instr(kind_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

        // run low at instruction end: back to IDLE with no done pulse.
        do_instr(K_ALU, 1'b0, 1'b0, 1'b0);
        chk("stop.idle", {20'd0, obsv()}, 32'd0);
        chk_cnt("stop");
        @(negedge clk);
        chk("stop.stays_idle", {20'd0, obsv()}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kgp_multicycle_seq.md
# kgp_multicycle_seq

Multicycle sequencer for the KGP-RISC datapath. It steps each instruction through fetch, decode, execute, memory and write-back. It consumes the decoded control signals (regWrite, memRead, memWrite, branch, brLink) and turns them into single-cycle strobes for the PC, IR, register file and data memory. It sits between the control decoder and the datapath, and absorbs the block-RAM read latency of the instruction and data memories.

## Interface
- MEM_LAT, 1: read latency of imem/dmem in cycles; legal range 1..3.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- halt  in  1  decoded halt instruction; valid in DECODE.
- regWrite  in  1  from control decoder.
- memRead  in  1  from control decoder.
- memWrite  in  1  from control decoder.
- brLink  in  1  from control decoder.
- branch  in  3  from control decoder; nonzero = branch class.
- brTaken  in  1  branch condition from the branch unit; valid in EXEC.
- imemEn  out  1  instruction-memory read strobe.
- irWrite  out  1  latch instruction register.
- pcWrite  out  1  update PC.
- pcSrcBr  out  1  1 = PC takes the branch target, 0 = PC+4.
- dmemEn  out  1  data-memory access strobe.
- dmemWe  out  1  data-memory write enable; qualified by dmemEn.
- rfWrite  out  1  register-file write enable.
- done  out  1  one-cycle pulse on entry to IDLE from halt.
- busy  out  1  state != IDLE.
- state  out  3  current state encoding (debug).
- cycleCnt  out  32  cycles spent outside IDLE (macro only).
- instrCnt  out  32  retired instructions (macro only).

## Operation
- States and encodings: IDLE=0, FETCH=1, FWAIT=2, DECODE=3, EXEC=4, MEM=5, MWAIT=6, WB=7.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: imemEn=1. Go to FWAIT.
- FWAIT: stay MEM_LAT cycles, tracked by an internal 2-bit wait counter. irWrite=1 in the last FWAIT cycle only. Then go to DECODE.
- DECODE: no strobes.
  - halt=1: go to IDLE, assert done in that transition cycle, do not update PC.
  - Otherwise go to EXEC.
- EXEC: pcWrite=1. pcSrcBr = (branch!=0) & brTaken, driven combinationally from brTaken. Next state, in priority order:
  - memWrite or memRead → MEM.
  - regWrite, or (branch!=0 & brLink) → WB.
  - Otherwise → instruction end.
- MEM: dmemEn=1, dmemWe=memWrite. If memRead=1 and memWrite=1, memWrite wins and the access is treated as a store.
  - Store → instruction end.
  - Load → MWAIT.
- MWAIT: stay MEM_LAT cycles, then go to WB. Read data is valid in the last MWAIT cycle.
- WB: rfWrite=1 for exactly one cycle → instruction end.
- Instruction end: run=1 → FETCH; run=0 → IDLE (no done pulse).
- Decoder inputs are sampled only in the states listed above. The datapath holds the IR stable from DECODE through WB.
- Every strobe is high for exactly one cycle per instruction, except imemEn and dmemEn, which are high only in FETCH and MEM.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, wait counter=0. All outputs 0, including done, busy and the counters.
- Reset asserted mid-instruction aborts immediately. No strobe is asserted after the reset edge.
- Cycles per instruction, L=MEM_LAT:
  - ALU / I-type: 4+L.
  - Load: 5+2L.
  - Store: 4+L.
  - Branch without link: 3+L.
  - Branch with link: 4+L.
- run deasserted mid-instruction does not abort; the current instruction completes.
- run toggled 1→0→1 within one instruction has no effect.
- halt is ignored in every state except DECODE.

## Configuration
- KGP_SEQ_PERF_CNT_EN defined:
  - cycleCnt increments every cycle with busy=1.
  - instrCnt increments on each instruction end and on halt.
  - Both wrap at 2^32 and clear only on reset.
- KGP_SEQ_PERF_CNT_EN undefined: cycleCnt and instrCnt are tied to 0, and no counter flops are synthesized.

## Test plan
- R-type, MEM_LAT=1, run=1, regWrite=1: state sequence 1,2,3,4,7,1. rfWrite high only in cycle 5. pcWrite=1, pcSrcBr=0 in cycle 4.
- Load, MEM_LAT=2: sequence 1,2,2,3,4,5,6,6,7 (9 cycles). dmemEn=1, dmemWe=0 in MEM. irWrite only in the second FWAIT cycle.
- Store with memRead=1 and memWrite=1 both set: MEM has dmemEn=1 and dmemWe=1, then FETCH. rfWrite never asserted.
- Branch, branch=3'b010, brLink=1, brTaken=1: in EXEC, pcWrite=1 and pcSrcBr=1, then WB with rfWrite=1. Repeat with brTaken=0: pcSrcBr=0.
- halt=1 in DECODE: next state IDLE, done pulses once, pcWrite stays 0. With the macro, instrCnt increments by 1.
- rst_n pulsed low in MWAIT: outputs 0 immediately, state=0. After release with run=1, the next cycle is FETCH and counters restart from 0.
